// File: rtl/pipe_reg_pkg.sv
// Shared helpers for the pipe_reg_chain delay line.
package pipe_reg_pkg;

    // Width of a counter that must hold 0..depth inclusive.
    function automatic int unsigned occ_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_reg_stage.sv
// One pipeline stage: a data register plus its valid bit.
module pipe_reg_stage #(
    parameter int unsigned      WIDTH      = 4,
    parameter bit               RESET_DATA = 1'b1,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             En,
    input  logic             Flush,
    input  logic [WIDTH-1:0] D,
    input  logic             D_Valid,
    output logic [WIDTH-1:0] Q,
    output logic             Q_Valid
);

    logic [WIDTH-1:0] data_d, data_q;
    logic             valid_d, valid_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (Rst || Flush) begin
            valid_d = 1'b0;
        end else if (En) begin
            valid_d = D_Valid;
            data_d  = D;
        end
    end

    always_ff @(posedge Clk) begin
        valid_q <= valid_d;
    end

    // Data register only sees reset when the datapath reset is enabled.
    if (RESET_DATA) begin : g_data_rst
        always_ff @(posedge Clk) begin
            if (Rst) begin
                data_q <= RESET_VAL;
            end else begin
                data_q <= data_d;
            end
        end
    end else begin : g_data_norst
        always_ff @(posedge Clk) begin
            if (!Rst) begin
                data_q <= data_d;
            end
        end
    end

    assign Q       = data_q;
    assign Q_Valid = valid_q;

endmodule

// File: rtl/pipe_reg_chain.sv
// DEPTH-stage delay line with bubble tracking, stall, flush and occupancy count.
module pipe_reg_chain
    import pipe_reg_pkg::*;
#(
    parameter int unsigned      WIDTH      = 4,
    parameter int unsigned      DEPTH      = 3,
    parameter bit               RESET_DATA = 1'b1,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0,
    localparam int unsigned     OCC_W      = occ_w(DEPTH)
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             En,
    input  logic             Flush,
    input  logic [WIDTH-1:0] D,
    input  logic             D_Valid,
    output logic [WIDTH-1:0] Q,
    output logic             Q_Valid,
    output logic [OCC_W-1:0] Occupancy
);

    logic [WIDTH-1:0] data_chain  [DEPTH+1];
    logic             valid_chain [DEPTH+1];
    logic [OCC_W-1:0] occ_d, occ_q;

    assign data_chain[0]  = D;
    assign valid_chain[0] = D_Valid;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        pipe_reg_stage #(
            .WIDTH      (WIDTH),
            .RESET_DATA (RESET_DATA),
            .RESET_VAL  (RESET_VAL)
        ) u_stage (
            .Clk     (Clk),
            .Rst     (Rst),
            .En      (En),
            .Flush   (Flush),
            .D       (data_chain[i]),
            .D_Valid (valid_chain[i]),
            .Q       (data_chain[i+1]),
            .Q_Valid (valid_chain[i+1])
        );
    end

    // An item entering and one leaving on the same edge cancel out.
    always_comb begin
        occ_d = occ_q;
        if (Rst || Flush) begin
            occ_d = '0;
        end else if (En) begin
            occ_d = occ_q + OCC_W'(D_Valid) - OCC_W'(valid_chain[DEPTH]);
        end
    end

    always_ff @(posedge Clk) begin
        occ_q <= occ_d;
    end

    assign Q         = data_chain[DEPTH];
    assign Q_Valid   = valid_chain[DEPTH];
    assign Occupancy = occ_q;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Self-checking bench: four pipe_reg_chain variants against an item-scoreboard model.
module tb_pipe_reg_chain;

    localparam int unsigned DEP [4] = '{3, 3, 1, 5};
    localparam bit          RD  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    localparam logic [3:0]  RV  [4] = '{4'h0, 4'h0, 4'h0, 4'h9};

    logic       Clk;
    logic       Rst, En, Flush, D_Valid;
    logic [3:0] D;

    logic [3:0] q_a  [4];
    logic       qv_a [4];
    logic [1:0] o0, o1;
    logic [0:0] o2;
    logic [2:0] o3;
    wire  [2:0] occ_a [4];

    assign occ_a[0] = {1'b0, o0};
    assign occ_a[1] = {1'b0, o1};
    assign occ_a[2] = {2'b0, o2};
    assign occ_a[3] = o3;

    pipe_reg_chain #(.WIDTH(4), .DEPTH(DEP[0]), .RESET_DATA(RD[0]), .RESET_VAL(RV[0])) u_d3 (
        .Clk(Clk), .Rst(Rst), .En(En), .Flush(Flush), .D(D), .D_Valid(D_Valid),
        .Q(q_a[0]), .Q_Valid(qv_a[0]), .Occupancy(o0)
    );
    pipe_reg_chain #(.WIDTH(4), .DEPTH(DEP[1]), .RESET_DATA(RD[1]), .RESET_VAL(RV[1])) u_d3n (
        .Clk(Clk), .Rst(Rst), .En(En), .Flush(Flush), .D(D), .D_Valid(D_Valid),
        .Q(q_a[1]), .Q_Valid(qv_a[1]), .Occupancy(o1)
    );
    pipe_reg_chain #(.WIDTH(4), .DEPTH(DEP[2]), .RESET_DATA(RD[2]), .RESET_VAL(RV[2])) u_d1 (
        .Clk(Clk), .Rst(Rst), .En(En), .Flush(Flush), .D(D), .D_Valid(D_Valid),
        .Q(q_a[2]), .Q_Valid(qv_a[2]), .Occupancy(o2)
    );
    pipe_reg_chain #(.WIDTH(4), .DEPTH(DEP[3]), .RESET_DATA(RD[3]), .RESET_VAL(RV[3])) u_d5 (
        .Clk(Clk), .Rst(Rst), .En(En), .Flush(Flush), .D(D), .D_Valid(D_Valid),
        .Q(q_a[3]), .Q_Valid(qv_a[3]), .Occupancy(o3)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: in-flight items tagged with the enabled-edge count at entry, and
    // the history of D values captured on enabled edges (newest first).
    int unsigned cnt    [4];
    int unsigned ent_q  [4][$];
    logic [3:0]  itm_q  [4][$];
    logic [3:0]  hist_q [4][$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_update();
        for (int k = 0; k < 4; k++) begin
            if (Rst) begin
                ent_q[k].delete();
                itm_q[k].delete();
                if (RD[k]) begin
                    hist_q[k].delete();
                    repeat (DEP[k]) hist_q[k].push_back(RV[k]);
                end
            end else if (Flush) begin
                ent_q[k].delete();
                itm_q[k].delete();
            end else if (En) begin
                cnt[k]++;
                hist_q[k].push_front(D);
                if (hist_q[k].size() > DEP[k]) void'(hist_q[k].pop_back());
                if (D_Valid) begin
                    ent_q[k].push_back(cnt[k]);
                    itm_q[k].push_back(D);
                end
                if (ent_q[k].size() > 0 && cnt[k] - ent_q[k][0] >= DEP[k]) begin
                    void'(ent_q[k].pop_front());
                    void'(itm_q[k].pop_front());
                end
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 4; k++) begin
            logic exp_qv;
            exp_qv = (ent_q[k].size() > 0) && (cnt[k] - ent_q[k][0] == DEP[k] - 1);
            check_eq($sformatf("i%0d occ", k), occ_a[k], ent_q[k].size());
            check_eq($sformatf("i%0d qv", k), qv_a[k], exp_qv);
            if (exp_qv) check_eq($sformatf("i%0d q_item", k), q_a[k], itm_q[k][0]);
            if (hist_q[k].size() == DEP[k])
                check_eq($sformatf("i%0d q_data", k), q_a[k], hist_q[k][DEP[k]-1]);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        model_update();
        @(negedge Clk);
        check_all();
    endtask

    task automatic push(input logic v, input logic [3:0] d);
        D_Valid = v;
        D       = d;
        step();
    endtask

    initial begin
        for (int k = 0; k < 4; k++) cnt[k] = 0;
        Rst = 1'b1; En = 1'b0; Flush = 1'b0; D = 4'h0; D_Valid = 1'b0;

        // Reset
        step();
        step();
        Rst = 1'b0;
        check_eq("rst_q", q_a[0], 4'h0);
        check_eq("rst_qv", qv_a[0], 1'b0);
        check_eq("rst_occ", occ_a[0], 0);
        check_eq("rst_q_d5", q_a[3], 4'h9);

        // Back-to-back stream then drain
        En = 1'b1;
        push(1'b1, 4'hA);
        push(1'b1, 4'h5);
        push(1'b1, 4'hC);
        check_eq("stream_q_a", q_a[0], 4'hA);
        check_eq("stream_occ3", occ_a[0], 3);
        repeat (5) push(1'b0, 4'($urandom_range(0, 15)));
        check_eq("drain_occ", occ_a[0], 0);

        // Stall with two items in flight
        push(1'b1, 4'hA);
        push(1'b1, 4'h5);
        En = 1'b0;
        repeat (4) push(1'b1, 4'($urandom_range(0, 15)));
        check_eq("stall_occ", occ_a[0], 2);
        check_eq("stall_qv", qv_a[0], 1'b0);
        En = 1'b1;
        push(1'b0, 4'h0);
        check_eq("resume_q", q_a[0], 4'hA);
        check_eq("resume_qv", qv_a[0], 1'b1);

        // Fill, then flush with a valid input on the same edge
        repeat (3) push(1'b1, 4'($urandom_range(0, 14)));
        check_eq("full_occ", occ_a[0], 3);
        Flush = 1'b1;
        push(1'b1, 4'hF);
        Flush = 1'b0;
        check_eq("flush_qv", qv_a[0], 1'b0);
        check_eq("flush_occ", occ_a[0], 0);
        repeat (4) push(1'b0, 4'h0);

        // Flush together with reset; reset mid-stream
        Flush = 1'b1; Rst = 1'b1;
        push(1'b1, 4'h3);
        Flush = 1'b0; Rst = 1'b0;
        check_eq("rstflush_occ", occ_a[0], 0);
        push(1'b1, 4'h7);
        push(1'b1, 4'h8);
        check_eq("mid_occ2", occ_a[0], 2);
        Rst = 1'b1;
        push(1'b1, 4'h2);
        Rst = 1'b0;
        check_eq("mid_rst_occ", occ_a[0], 0);
        check_eq("mid_rst_q", q_a[0], 4'h0);
        repeat (3) push(1'b1, 4'h6);
        repeat (3) push(1'b0, 4'h1);

        // Random traffic
        for (int c = 0; c < 1000; c++) begin
            En      = ($urandom_range(0, 9) < 7);
            Flush   = ($urandom_range(0, 99) < 4);
            Rst     = ($urandom_range(0, 199) == 0);
            D_Valid = $urandom_range(0, 1) == 1;
            D       = 4'($urandom_range(0, 15));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
